// File: rtl/thor2024_commit_rob_if.sv
// Dispatch, writeback and commit signal bundle for the in-order completion buffer.
// The master side drives dispatch/writeback; the slave side (the buffer) returns tags and commits.
interface thor2024_commit_rob_if #(
  parameter int DEPTH = 8,
  parameter int WID   = 64
);
  localparam int TW = $clog2(DEPTH);

  logic           flush;
  logic           enq0_v;
  logic           enq1_v;
  logic [5:0]     enq0_tgt;
  logic [5:0]     enq1_tgt;
  logic           enq_rdy;
  logic [TW-1:0]  enq0_tag;
  logic [TW-1:0]  enq1_tag;
  logic           wb_v;
  logic [TW-1:0]  wb_tag;
  logic [WID-1:0] wb_res;
  logic           commit0_v;
  logic           commit1_v;
  logic [5:0]     commit0_tgt;
  logic [5:0]     commit1_tgt;
  logic [WID-1:0] commit0_bus;
  logic [WID-1:0] commit1_bus;
  logic [TW:0]    count;

  modport master (
    output flush, enq0_v, enq1_v, enq0_tgt, enq1_tgt, wb_v, wb_tag, wb_res,
    input  enq_rdy, enq0_tag, enq1_tag, commit0_v, commit1_v,
           commit0_tgt, commit1_tgt, commit0_bus, commit1_bus, count
  );

  modport slave (
    input  flush, enq0_v, enq1_v, enq0_tgt, enq1_tgt, wb_v, wb_tag, wb_res,
    output enq_rdy, enq0_tag, enq1_tag, commit0_v, commit1_v,
           commit0_tgt, commit1_tgt, commit0_bus, commit1_bus, count
  );
endinterface

// File: rtl/thor2024_commit_rob.sv
// In-order completion buffer: two-wide dispatch, tagged out-of-order writeback,
// and up to two registered in-order commits per cycle.
module thor2024_commit_rob #(
  parameter int DEPTH = 8,
  parameter int WID   = 64
) (
  input logic                  clk,
  input logic                  rst,
  thor2024_commit_rob_if.slave rob
);
  localparam int TW = $clog2(DEPTH);
  typedef logic [TW-1:0] tag_t;
  typedef logic [TW:0]   cnt_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [5:0]       tgt_q [DEPTH];
  logic [5:0]       tgt_d [DEPTH];
  logic [WID-1:0]   res_q [DEPTH];
  logic [WID-1:0]   res_d [DEPTH];
  tag_t             head_q, head_d;
  tag_t             tail_q, tail_d;
  cnt_t             count_q, count_d;

  logic             c0_v_q, c0_v_d;
  logic             c1_v_q, c1_v_d;
  logic [5:0]       c0_tgt_q, c0_tgt_d;
  logic [5:0]       c1_tgt_q, c1_tgt_d;
  logic [WID-1:0]   c0_bus_q, c0_bus_d;
  logic [WID-1:0]   c1_bus_q, c1_bus_d;

  tag_t             head1;
  tag_t             tail1;
  logic             enq_rdy;
  logic             c0;
  logic             c1;
  logic             acc0;
  logic             acc1;
  logic             wb_ok;
  cnt_t             n_enq;
  cnt_t             n_com;

  // Every decision below looks only at registered state, so a slot freed by a
  // commit cannot be reused and a freshly enqueued slot cannot accept writeback
  // until the following cycle.
  assign head1   = head_q + tag_t'(1);
  assign tail1   = tail_q + tag_t'(1);
  assign enq_rdy = (count_q <= cnt_t'(DEPTH - 2));
  assign c0      = valid_q[head_q] & done_q[head_q];
  assign c1      = c0 & valid_q[head1] & done_q[head1];
  assign acc0    = enq_rdy & rob.enq0_v;
  assign acc1    = acc0 & rob.enq1_v;
  assign wb_ok   = rob.wb_v & valid_q[rob.wb_tag] & ~done_q[rob.wb_tag];
  assign n_enq   = cnt_t'(acc0) + cnt_t'(acc1);
  assign n_com   = cnt_t'(c0) + cnt_t'(c1);

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    tgt_d    = tgt_q;
    res_d    = res_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    c0_v_d   = 1'b0;
    c1_v_d   = 1'b0;
    c0_tgt_d = c0_tgt_q;
    c1_tgt_d = c1_tgt_q;
    c0_bus_d = c0_bus_q;
    c1_bus_d = c1_bus_q;

    if (c0) begin
      c0_v_d          = 1'b1;
      c0_tgt_d        = tgt_q[head_q];
      c0_bus_d        = res_q[head_q];
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (c1) begin
      c1_v_d         = 1'b1;
      c1_tgt_d       = tgt_q[head1];
      c1_bus_d       = res_q[head1];
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end
    head_d = head_q + tag_t'(n_com);

    // A retiring entry is already done, so writeback can never revive it.
    if (wb_ok) begin
      done_d[rob.wb_tag] = 1'b1;
      res_d[rob.wb_tag]  = rob.wb_res;
    end

    if (acc0) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tgt_d[tail_q]   = rob.enq0_tgt;
    end
    if (acc1) begin
      valid_d[tail1] = 1'b1;
      done_d[tail1]  = 1'b0;
      tgt_d[tail1]   = rob.enq1_tgt;
    end
    tail_d  = tail_q + tag_t'(n_enq);
    count_d = count_q + n_enq - n_com;

    if (rob.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      c0_v_d  = 1'b0;
      c1_v_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      c0_v_q   <= 1'b0;
      c1_v_q   <= 1'b0;
      c0_tgt_q <= '0;
      c1_tgt_q <= '0;
      c0_bus_q <= '0;
      c1_bus_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      c0_v_q   <= c0_v_d;
      c1_v_q   <= c1_v_d;
      c0_tgt_q <= c0_tgt_d;
      c1_tgt_q <= c1_tgt_d;
      c0_bus_q <= c0_bus_d;
      c1_bus_q <= c1_bus_d;
      tgt_q    <= tgt_d;
      res_q    <= res_d;
    end
  end

  assign rob.enq_rdy     = enq_rdy;
  assign rob.enq0_tag    = tail_q;
  assign rob.enq1_tag    = tail1;
  assign rob.commit0_v   = c0_v_q;
  assign rob.commit1_v   = c1_v_q;
  assign rob.commit0_tgt = c0_tgt_q;
  assign rob.commit1_tgt = c1_tgt_q;
  assign rob.commit0_bus = c0_bus_q;
  assign rob.commit1_bus = c1_bus_q;
  assign rob.count       = count_q;

  a_c1_needs_c0: assert property (@(posedge clk) disable iff (rst) c1_v_q |-> c0_v_q);
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= cnt_t'(DEPTH));
endmodule

// File: tb/tb_thor2024_commit_rob.sv
// Bench for thor2024_commit_rob: queue-based program-order model drives a commit
// scoreboard; an independent monitor pops expectations whenever a commit pulse appears.
module tb_thor2024_commit_rob;
  localparam int DEPTH = 8;
  localparam int WID   = 64;
  localparam int TW    = $clog2(DEPTH);

  typedef struct {
    int             tag;
    logic [5:0]     tgt;
    bit             done;
    logic [WID-1:0] res;
  } ent_t;

  typedef struct {
    int             cyc;
    int             slot;
    logic [5:0]     tgt;
    logic [WID-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  ent_t rob_m[$];
  exp_t sb[$];
  int   tail_m = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  thor2024_commit_rob_if #(.DEPTH(DEPTH), .WID(WID)) rob_bus ();

  thor2024_commit_rob #(.DEPTH(DEPTH), .WID(WID)) dut (
    .clk (clk),
    .rst (rst),
    .rob (rob_bus)
  );

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    checkVal("count", 64'(rob_bus.count), 64'(rob_m.size()));
    checkVal("enq_rdy", 64'(rob_bus.enq_rdy), 64'(rob_m.size() <= DEPTH - 2));
    checkVal("enq0_tag", 64'(rob_bus.enq0_tag), 64'(tail_m));
    checkVal("enq1_tag", 64'(rob_bus.enq1_tag), 64'((tail_m + 1) % DEPTH));
  endtask

  // Program-order view: oldest entry at the front, commits come off the front.
  task automatic modelStep(input bit fl, input bit e0, input bit e1, input logic [5:0] t0,
                           input logic [5:0] t1, input bit wv, input int wt, input logic [WID-1:0] wr);
    int ncom = 0;
    bit rdy  = (rob_m.size() <= DEPTH - 2);
    if (fl) begin
      rob_m.delete();
      tail_m = 0;
      return;
    end
    if (rob_m.size() >= 1 && rob_m[0].done) begin
      ncom = 1;
      if (rob_m.size() >= 2 && rob_m[1].done) ncom = 2;
    end
    for (int i = 0; i < ncom; i++) sb.push_back('{cyc + 1, i, rob_m[i].tgt, rob_m[i].res});
    if (wv) begin
      foreach (rob_m[i]) begin
        if (rob_m[i].tag == wt && !rob_m[i].done) begin
          rob_m[i].done = 1'b1;
          rob_m[i].res  = wr;
        end
      end
    end
    repeat (ncom) void'(rob_m.pop_front());
    if (rdy && e0) begin
      rob_m.push_back('{tail_m, t0, 1'b0, '0});
      tail_m = (tail_m + 1) % DEPTH;
      if (e1) begin
        rob_m.push_back('{tail_m, t1, 1'b0, '0});
        tail_m = (tail_m + 1) % DEPTH;
      end
    end
  endtask

  task automatic applyStimulus(input bit fl, input bit e0, input bit e1, input logic [5:0] t0,
                               input logic [5:0] t1, input bit wv, input int wt, input logic [WID-1:0] wr);
    @(negedge clk);
    checkOutput();
    rob_bus.flush    = fl;
    rob_bus.enq0_v   = e0;
    rob_bus.enq1_v   = e1;
    rob_bus.enq0_tgt = t0;
    rob_bus.enq1_tgt = t1;
    rob_bus.wb_v     = wv;
    rob_bus.wb_tag   = TW'(wt);
    rob_bus.wb_res   = wr;
    modelStep(fl, e0, e1, t0, t1, wv, wt, wr);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 0, '0);
  endtask

  task automatic wbOnly(input int tag, input logic [WID-1:0] val);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, tag, val);
  endtask

  task automatic drainModel();
    int pend[$];
    pend.delete();
    foreach (rob_m[i]) if (!rob_m[i].done) pend.push_back(rob_m[i].tag);
    foreach (pend[i]) wbOnly(pend[i], {$urandom, $urandom});
    idle(4);
  endtask

  task automatic monCompare(input int slot, input logic [5:0] tgt, input logic [WID-1:0] bus);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL commit%0d_unexpected: got tgt=%0d bus=%0h expected no commit (cycle %0d)",
               slot, tgt, bus, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.cyc != cyc || e.slot != slot || e.tgt !== tgt || e.res !== bus) begin
      fails++;
      $display("[TB] FAIL commit%0d: got cyc=%0d slot=%0d tgt=%0d bus=%0h expected cyc=%0d slot=%0d tgt=%0d bus=%0h",
               slot, cyc, slot, tgt, bus, e.cyc, e.slot, e.tgt, e.res);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("[TB] FAIL missing_commit: got no pulse expected slot=%0d tgt=%0d bus=%0h at cycle %0d",
                 sb[0].slot, sb[0].tgt, sb[0].res, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (rob_bus.commit0_v) monCompare(0, rob_bus.commit0_tgt, rob_bus.commit0_bus);
      if (rob_bus.commit1_v) monCompare(1, rob_bus.commit1_tgt, rob_bus.commit1_bus);
    end
  end

  initial begin
    int cand[$];
    bit fl, e0, e1, wv;
    int wt;

    rob_bus.flush    = 1'b0;
    rob_bus.enq0_v   = 1'b0;
    rob_bus.enq1_v   = 1'b0;
    rob_bus.enq0_tgt = '0;
    rob_bus.enq1_tgt = '0;
    rob_bus.wb_v     = 1'b0;
    rob_bus.wb_tag   = '0;
    rob_bus.wb_res   = '0;

    #1;
    checkVal("reset_count", 64'(rob_bus.count), 64'd0);
    checkVal("reset_enq_rdy", 64'(rob_bus.enq_rdy), 64'd1);
    checkVal("reset_commit0_v", 64'(rob_bus.commit0_v), 64'd0);
    checkVal("reset_commit1_v", 64'(rob_bus.commit1_v), 64'd0);
    checkVal("reset_commit0_bus", rob_bus.commit0_bus, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-stream reset with five live entries
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd1, 6'd2, 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd3, 6'd4, 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 6'd0, 1'b0, 0, '0);
    idle(1);
    #2 rst = 1'b1;
    #1;
    checkVal("midrst_count", 64'(rob_bus.count), 64'd0);
    checkVal("midrst_enq_rdy", 64'(rob_bus.enq_rdy), 64'd1);
    checkVal("midrst_commit0_v", 64'(rob_bus.commit0_v), 64'd0);
    checkVal("midrst_enq0_tag", 64'(rob_bus.enq0_tag), 64'd0);
    rob_m.delete();
    sb.delete();
    tail_m = 0;
    @(negedge clk);
    rst = 1'b0;

    // Dual enqueue r3/r4, results arrive youngest first
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd3, 6'd4, 1'b0, 0, '0);
    wbOnly(1, 64'hBB);
    wbOnly(0, 64'hAA);
    idle(3);

    // Ordering: lone commit, then tag held behind an older pending entry
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd10, 6'd11, 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd12, 6'd0, 1'b0, 0, '0);
    wbOnly(2, 64'h1002);
    wbOnly(4, 64'h1004);
    idle(2);
    wbOnly(3, 64'h1003);
    idle(3);

    // Fill to full, try enqueue at full, then free two slots
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd60, 6'd61, 1'b0, 0, '0);
    wbOnly(rob_m[0].tag, 64'h2000);
    wbOnly(rob_m[1].tag, 64'h2001);
    idle(3);
    drainModel();

    // Wrap: 20 enqueue/commit pairs
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 6'(i), 6'd0, 1'b0, 0, '0);
      wbOnly(rob_m[rob_m.size() - 1].tag, 64'(i) + 64'h300);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd20, 6'd21, 1'b0, 0, '0);
    drainModel();

    // Corners: wb to empty slot, enq1 alone, double wb, flush over pending commits
    wbOnly(5, 64'hDEAD);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 6'd7, 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd8, 6'd0, 1'b0, 0, '0);
    wbOnly(rob_m[0].tag, 64'h111);
    wbOnly(rob_m[0].tag, 64'h222);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd13, 6'd14, 1'b0, 0, '0);
    wbOnly(rob_m[0].tag, 64'h333);
    wbOnly(rob_m[1].tag, 64'h444);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd15, 6'd16, 1'b1, 0, 64'h555);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      fl = ($urandom_range(0, 99) == 0);
      e0 = ($urandom_range(0, 3) != 0);
      e1 = $urandom_range(0, 1) == 1;
      cand.delete();
      foreach (rob_m[i]) if (!rob_m[i].done) cand.push_back(rob_m[i].tag);
      wv = ($urandom_range(0, 3) != 0);
      if (cand.size() > 0 && $urandom_range(0, 4) != 0)
        wt = cand[$urandom_range(0, cand.size() - 1)];
      else
        wt = $urandom_range(0, DEPTH - 1);
      applyStimulus(fl, e0, e1, 6'($urandom), 6'($urandom), wv, wt, {$urandom, $urandom});
    end
    drainModel();
    idle(2);
    checkVal("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
